// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers (EX/MEM/WB) for forwarding, detects
// load-use hazards and drives stall/bubble controls; zero added latency, mem_busy freezes all state.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic [REG_AW-1:0] RD_EX,
  output logic [REG_AW-1:0] RD_MEM,
  output logic [REG_AW-1:0] RD_WB,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } ex_slot_t;

  // The load flag only matters while the instruction sits in EX, so the
  // later slots carry just valid and destination.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } fwd_slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_slot_t  ex_q;
  fwd_slot_t mem_q;
  fwd_slot_t wb_q;

  logic src_hit;
  logic lu;
  logic ex_load;

  always_comb begin
    src_hit = (id_use_rs && (ex_q.rd == id_rs)) ||
              (id_use_rt && (ex_q.rd == id_rt));
    lu      = id_valid && !flush && ex_q.v && ex_q.ld &&
              (ex_q.rd != '0) && src_hit;
    ex_load = id_valid && !lu && !flush;
  end

  assign pc_we       = !(lu || mem_busy);
  assign ifid_we     = !(lu || mem_busy);
  assign idex_bubble = !mem_busy && (lu || flush);

  assign RD_EX  = ex_q.v  ? ex_q.rd  : '0;
  assign RD_MEM = mem_q.v ? mem_q.rd : '0;
  assign RD_WB  = wb_q.v  ? wb_q.rd  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= '{v: ex_q.v, rd: ex_q.rd};
      if (ex_load) begin
        ex_q <= '{v: 1'b1, rd: id_rd, ld: id_is_load};
      end else begin
        ex_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (lu && !mem_busy && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue, a monitor pops and compares them mid-cycle.
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              flush;
  logic              mem_busy;
  logic              cnt_clr;
  logic [REG_AW-1:0] RD_EX;
  logic [REG_AW-1:0] RD_MEM;
  logic [REG_AW-1:0] RD_WB;
  logic              pc_we;
  logic              ifid_we;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string             name;
    logic [REG_AW-1:0] ex;
    logic [REG_AW-1:0] mem;
    logic [REG_AW-1:0] wb;
    logic              pc;
    logic              bub;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .flush      (flush),
    .mem_busy   (mem_busy),
    .cnt_clr    (cnt_clr),
    .RD_EX      (RD_EX),
    .RD_MEM     (RD_MEM),
    .RD_WB      (RD_WB),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .idex_bubble(idex_bubble),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs at the falling edge and queue what the outputs
  // must show before the next rising edge.
  task automatic cyc(input string nm, input logic r, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] rd, input logic ld,
                     input logic fl, input logic bz, input logic clr,
                     input logic [4:0] eex, input logic [4:0] emem,
                     input logic [4:0] ewb, input logic epc, input logic ebub,
                     input logic [3:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs;
    id_use_rt = urt; id_rd = rd; id_is_load = ld; flush = fl;
    mem_busy = bz; cnt_clr = clr;
    e.name = nm; e.ex = eex; e.mem = emem; e.wb = ewb;
    e.pc = epc; e.bub = ebub; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (RD_EX !== e.ex || RD_MEM !== e.mem || RD_WB !== e.wb ||
          pc_we !== e.pc || ifid_we !== e.pc || idex_bubble !== e.bub ||
          stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got ex=%0d mem=%0d wb=%0d pc_we=%b ifid_we=%b bub=%b cnt=%0d, expected ex=%0d mem=%0d wb=%0d pc_we=%b ifid_we=%b bub=%b cnt=%0d",
                 e.name, RD_EX, RD_MEM, RD_WB, pc_we, ifid_we, idex_bubble, stall_cnt,
                 e.ex, e.mem, e.wb, e.pc, e.pc, e.bub, e.cnt);
      end
    end
  end

  initial begin
    logic [3:0] cl;
    logic [3:0] cn;
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0;
    id_use_rt = 0; id_rd = 0; id_is_load = 0; flush = 0; mem_busy = 0;
    cnt_clr = 0;
    #1 rst = 1'b0;
    //   name          r v rs rt urs urt rd ld fl bz clr   ex mem wb pc bub cnt
    cyc("reset",       0,0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    cyc("idle",        1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    cyc("lw_r5",       1,1, 0, 0, 0, 0,  5, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    cyc("lu_stall",    1,1, 5, 1, 1, 1,  3, 0, 0, 0, 0,   5, 0, 0, 0, 1, 0);
    cyc("lu_release",  1,1, 5, 1, 1, 1,  3, 0, 0, 0, 0,   0, 5, 0, 1, 0, 1);
    cyc("drain",       1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   3, 0, 5, 1, 0, 1);
    cyc("lw_r0",       1,1, 0, 0, 0, 0,  0, 1, 0, 0, 0,   0, 3, 0, 1, 0, 1);
    cyc("use_r0",      1,1, 0, 0, 1, 1,  2, 0, 0, 0, 0,   0, 0, 3, 1, 0, 1);
    cyc("lw_r5_b",     1,1, 0, 0, 0, 0,  5, 1, 0, 0, 0,   2, 0, 0, 1, 0, 1);
    cyc("rs_not_used", 1,1, 5, 6, 0, 1,  9, 0, 0, 0, 0,   5, 2, 0, 1, 0, 1);
    cyc("add_r7",      1,1, 0, 0, 0, 0,  7, 0, 0, 0, 0,   9, 5, 2, 1, 0, 1);
    cyc("use_r7",      1,1, 7, 0, 1, 0,  8, 0, 0, 0, 0,   7, 9, 5, 1, 0, 1);
    cyc("lw_r4",       1,1, 0, 0, 0, 0,  4, 1, 0, 0, 0,   8, 7, 9, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("busy_hold", 1,1, 4, 0, 1, 0, 10, 0, 0, 1, 0,   4, 8, 7, 0, 0, 1);
    cyc("busy_drop",   1,1, 4, 0, 1, 0, 10, 0, 0, 0, 0,   4, 8, 7, 0, 1, 1);
    cyc("after_busy",  1,1, 4, 0, 1, 0, 10, 0, 0, 0, 0,   0, 4, 8, 1, 0, 2);
    cyc("lw_r6",       1,1, 0, 0, 0, 0,  6, 1, 0, 0, 0,  10, 0, 4, 1, 0, 2);
    cyc("flush_lu",    1,1, 0, 6, 0, 1, 11, 0, 1, 0, 0,   6,10, 0, 1, 1, 2);
    cyc("lw_self",     1,1, 5, 0, 1, 0,  5, 1, 0, 0, 0,   0, 6,10, 1, 0, 2);
    // A load of r5 that reads r5 stalls on itself every other cycle.
    for (int i = 0; i < 16; i++) begin
      cl = (2 + i > 15) ? 4'd15 : 4'(2 + i);
      cn = (3 + i > 15) ? 4'd15 : 4'(3 + i);
      cyc("sat_lu",    1,1, 5, 0, 1, 0,  5, 1, 0, 0, 0,   5, 0, (i == 0) ? 5'd6 : 5'd5, 0, 1, cl);
      cyc("sat_pass",  1,1, 5, 0, 1, 0,  5, 1, 0, 0, 0,   0, 5, 0, 1, 0, cn);
    end
    cyc("cnt_clr_lu",  1,1, 5, 0, 1, 0,  5, 1, 0, 0, 1,   5, 0, 5, 0, 1,15);
    cyc("after_clr",   1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 5, 0, 1, 0, 0);
    cyc("r_lw",        1,1, 0, 0, 0, 0,  5, 1, 0, 0, 0,   0, 0, 5, 1, 0, 0);
    cyc("r_lu",        1,1, 5, 0, 1, 0,  3, 0, 0, 0, 0,   5, 0, 0, 0, 1, 0);
    cyc("r_lw2",       1,1, 5, 0, 1, 0,  5, 1, 0, 0, 0,   0, 5, 0, 1, 0, 1);
    cyc("r_busy_lu",   1,1, 5, 0, 1, 0,  5, 1, 0, 1, 0,   5, 0, 5, 0, 0, 1);
    cyc("rst_mid",     0,1, 5, 0, 1, 0,  5, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    cyc("rst_hold",    0,1, 5, 0, 1, 0,  5, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    cyc("post_rst",    1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
